// File: rtl/ps2_temp_ctrl.sv
// ps2_temp_ctrl: sequences PS/2 scan codes into the temperature decoder.
// Filters F0 (break) and E0 (extended) prefixes. Make codes are presented to
// the decoder, and the result is captured one cycle later. The block holds
// the setpoint and a sticky smoke alarm.
// Optional feature macro: KEY_REPEAT_FILTER_EN. When it is defined, a
// typematic repeat of the last make code is ignored until that key's break
// sequence is received.
module ps2_temp_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic [6:0] deco_value,
    output logic [7:0] deco_code,
    output logic [6:0] temp_out,
    output logic       temp_valid,
    output logic       new_temp_tick,
    output logic       smoke_alarm,
    input  logic       alarm_clear,
    output logic       busy
);

    localparam logic [7:0]       BRK_CODE  = 8'hF0;
    localparam logic [7:0]       EXT_CODE  = 8'hE0;
    localparam logic [6:0]       SMOKE_VAL = 7'h3C;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_LOOKUP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer;
    logic [7:0]       last_make;
    logic             is_repeat;
    logic             load_code;
    logic             timeout;
    logic             smoke_set;

`ifdef KEY_REPEAT_FILTER_EN
    // A held key resends its make code; drop it until the break re-arms it.
    assign is_repeat = (last_make != 8'h00) && (rx_data == last_make);
`else
    assign is_repeat = 1'b0;
`endif

    assign timeout = (timer == TMO_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; LOOKUP always lasts one cycle, so ticks arriving during it are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_done_tick) begin
                    if (rx_data == BRK_CODE)      state_nxt = S_BRK;
                    else if (rx_data == EXT_CODE) state_nxt = S_EXT;
                    else if (!is_repeat)          state_nxt = S_LOOKUP;
                end
            end
            S_EXT: begin
                if (rx_done_tick)  state_nxt = (rx_data == BRK_CODE) ? S_BRK : S_IDLE;
                else if (timeout)  state_nxt = S_IDLE;
            end
            S_BRK: begin
                if (rx_done_tick || timeout) state_nxt = S_IDLE;
            end
            S_LOOKUP: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        busy      = (state != S_IDLE);
        load_code = (state == S_IDLE) && (state_nxt == S_LOOKUP);
        smoke_set = (state == S_LOOKUP) && (deco_value == SMOKE_VAL);
    end

    // Prefix timer: cleared on every state change, counts while waiting in BRK/EXT
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               timer <= '0;
        else if (state_nxt != state)             timer <= '0;
        else if (state == S_BRK || state == S_EXT) timer <= timer + 1'b1;
        else                                     timer <= '0;
    end

    // Datapath: decoder code, setpoint capture, key tracking and sticky alarm
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deco_code     <= 8'h00;
            last_make     <= 8'h00;
            temp_out      <= 7'd0;
            temp_valid    <= 1'b0;
            new_temp_tick <= 1'b0;
            smoke_alarm   <= 1'b0;
        end else begin
            new_temp_tick <= 1'b0;
            if (load_code) deco_code <= rx_data;
            if (state == S_BRK && rx_done_tick && rx_data == last_make)
                last_make <= 8'h00;
            if (state == S_LOOKUP && deco_value != 7'd0) begin
                last_make <= deco_code;
                if (deco_value != SMOKE_VAL) begin
                    temp_out      <= deco_value;
                    temp_valid    <= 1'b1;
                    new_temp_tick <= 1'b1;
                end
            end
            // Set has priority over a simultaneous clear
            if (smoke_set)        smoke_alarm <= 1'b1;
            else if (alarm_clear) smoke_alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_temp_ctrl.sv
// Self-checking bench for ps2_temp_ctrl with a behavioural scan-code decoder.
module tb_ps2_temp_ctrl;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [6:0] deco_value;
    logic [7:0] deco_code;
    logic [6:0] temp_out;
    logic       temp_valid;
    logic       new_temp_tick;
    logic       smoke_alarm;
    logic       alarm_clear;
    logic       busy;

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        logic [7:0] code;
        logic       exp_tick;
        logic [6:0] exp_temp;
        logic       exp_smoke;
    } vec_t;
    vec_t vecs[5];

    ps2_temp_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .deco_value(deco_value), .deco_code(deco_code), .temp_out(temp_out),
        .temp_valid(temp_valid), .new_temp_tick(new_temp_tick),
        .smoke_alarm(smoke_alarm), .alarm_clear(alarm_clear), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] deco_fn(input logic [7:0] c);
        case (c)
            8'h16:   return 7'h0A;
            8'h1E:   return 7'h0F;
            8'h26:   return 7'h14;
            8'h25:   return 7'h19;
            8'h45:   return 7'h29;
            8'h75:   return 7'h30;
            8'h33:   return 7'h3C;
            default: return 7'h00;
        endcase
    endfunction

    assign deco_value = deco_fn(deco_code);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every setpoint pulse must match the oldest expected value
    always @(negedge clk) begin
        if (!reset && new_temp_tick) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected tick: temp_out=%0h with empty queue", temp_out);
            end else begin
                chk("tick temp", {25'd0, temp_out}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        idle(2);
    endtask

    initial begin
        int t0;
        vecs[0] = '{8'h1E, 1'b1, 7'h0F, 1'b0};
        vecs[1] = '{8'h1C, 1'b0, 7'h0F, 1'b0};
        vecs[2] = '{8'h45, 1'b1, 7'h29, 1'b0};
        vecs[3] = '{8'h33, 1'b0, 7'h29, 1'b1};
        vecs[4] = '{8'h16, 1'b1, 7'h0A, 1'b1};

        reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; alarm_clear = 1'b0;
        idle(3);
        reset = 1'b0;
        chk("rst temp_out", {25'd0, temp_out}, 32'd0);
        chk("rst temp_valid", {31'd0, temp_valid}, 32'd0);
        chk("rst tick", {31'd0, new_temp_tick}, 32'd0);
        chk("rst smoke", {31'd0, smoke_alarm}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst deco_code", {24'd0, deco_code}, 32'd0);

        // Latency: tick in N, deco_code/busy in N+1, result in N+2
        exp_q.push_back(7'h14);
        send(8'h26);
        chk("lat deco_code", {24'd0, deco_code}, 32'h26);
        chk("lat busy N+1", {31'd0, busy}, 32'd1);
        chk("lat tick N+1", {31'd0, new_temp_tick}, 32'd0);
        @(negedge clk);
        chk("lat temp N+2", {25'd0, temp_out}, 32'h14);
        chk("lat valid N+2", {31'd0, temp_valid}, 32'd1);
        chk("lat tick N+2", {31'd0, new_temp_tick}, 32'd1);
        chk("lat busy N+2", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("lat tick N+3", {31'd0, new_temp_tick}, 32'd0);

        // Table-driven make codes
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].exp_tick) exp_q.push_back(vecs[i].exp_temp);
            send_gap(vecs[i].code);
            chk("vec temp", {25'd0, temp_out}, {25'd0, vecs[i].exp_temp});
            chk("vec smoke", {31'd0, smoke_alarm}, {31'd0, vecs[i].exp_smoke});
        end

        // Alarm clear, then set and clear together in the LOOKUP cycle
        @(negedge clk); alarm_clear = 1'b1;
        @(negedge clk); alarm_clear = 1'b0;
        chk("alarm cleared", {31'd0, smoke_alarm}, 32'd0);
        send(8'h33);
        alarm_clear = 1'b1;
        @(negedge clk); alarm_clear = 1'b0;
        chk("alarm set wins", {31'd0, smoke_alarm}, 32'd1);
        chk("alarm temp kept", {25'd0, temp_out}, 32'h0A);
        @(negedge clk); alarm_clear = 1'b1;
        @(negedge clk); alarm_clear = 1'b0;
        chk("alarm cleared 2", {31'd0, smoke_alarm}, 32'd0);

        // Typematic repeat sequence
        t0 = tick_cnt;
`ifdef KEY_REPEAT_FILTER_EN
        repeat (2) exp_q.push_back(7'h19);
`else
        repeat (4) exp_q.push_back(7'h19);
`endif
        send_gap(8'h25); send_gap(8'h25); send_gap(8'h25);
        send_gap(8'hF0); send_gap(8'h25); send_gap(8'h25);
        idle(1);
`ifdef KEY_REPEAT_FILTER_EN
        chk("repeat ticks", tick_cnt - t0, 32'd2);
`else
        chk("repeat ticks", tick_cnt - t0, 32'd4);
`endif
        chk("repeat temp", {25'd0, temp_out}, 32'h19);

        // Break prefix timeout boundary
        send(8'hF0);
        chk("tmo busy start", {31'd0, busy}, 32'd1);
        idle(TMO - 1);
        chk("tmo busy last", {31'd0, busy}, 32'd1);
        idle(1);
        chk("tmo idle", {31'd0, busy}, 32'd0);
        exp_q.push_back(7'h0F);
        send_gap(8'h1E);
        chk("tmo then make", {25'd0, temp_out}, 32'h0F);

        // Break sequence inside window is never decoded
        t0 = tick_cnt;
        send_gap(8'hF0); send_gap(8'h1E);
        chk("break no tick", tick_cnt - t0, 32'd0);
        chk("break idle", {31'd0, busy}, 32'd0);

        // Extended codes are discarded
        send_gap(8'hE0); send_gap(8'h75);
        chk("ext idle", {31'd0, busy}, 32'd0);
        send_gap(8'hE0); send_gap(8'hF0); send_gap(8'h75);
        chk("ext brk idle", {31'd0, busy}, 32'd0);
        chk("ext temp", {25'd0, temp_out}, 32'h0F);
        chk("ext no tick", tick_cnt - t0, 32'd0);

        // Tick during LOOKUP is dropped
        t0 = tick_cnt;
        exp_q.push_back(7'h0A);
        @(negedge clk); rx_data = 8'h16; rx_done_tick = 1'b1;
        @(negedge clk); rx_data = 8'h45; rx_done_tick = 1'b1;
        @(negedge clk); rx_done_tick = 1'b0;
        chk("drop temp", {25'd0, temp_out}, 32'h0A);
        idle(2);
        chk("drop temp hold", {25'd0, temp_out}, 32'h0A);
        chk("drop busy", {31'd0, busy}, 32'd0);
        chk("drop ticks", tick_cnt - t0, 32'd1);

        // Asynchronous reset while in BREAK
        send_gap(8'h33);
        chk("pre-rst smoke", {31'd0, smoke_alarm}, 32'd1);
        send(8'hF0);
        reset = 1'b1;
        #1;
        chk("arst temp", {25'd0, temp_out}, 32'd0);
        chk("arst valid", {31'd0, temp_valid}, 32'd0);
        chk("arst smoke", {31'd0, smoke_alarm}, 32'd0);
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst deco_code", {24'd0, deco_code}, 32'd0);
        @(negedge clk); reset = 1'b0;
        exp_q.push_back(7'h29);
        send_gap(8'h45);
        chk("post-rst temp", {25'd0, temp_out}, 32'h29);
        chk("post-rst valid", {31'd0, temp_valid}, 32'd1);

        idle(3);
        chk("queue drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
